// File: rtl/uart_rx_buffer_ctrl.sv
// UART receive buffer: captures bytes from uart_receiver into a show-ahead FIFO
// and keeps sticky frame/overshoot flags. Define UART_RX_IRQ_EN for the irq output.
module uart_rx_buffer_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         rx_data_in,
    input  logic                          rx_strobe_data_ready_level,
    input  logic                          rx_frame_error,
    output logic                          rx_ack,
    input  logic                          cpu_strobe_read_data,
    input  logic                          cmd_clear_frame_error,
    input  logic                          cmd_clear_overshoot_error,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic [7:0]                    status_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef UART_RX_IRQ_EN
    ,
    input  logic                          irq_mask,
    output logic                          irq
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  frame_error, overshoot_error;
    logic                  empty, full, pop, capture, push, overrun;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = cpu_strobe_read_data && !empty;
    assign capture = (state == IDLE) && rx_strobe_data_ready_level;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
    assign push    = capture && !rx_frame_error && (!full || pop);
    assign overrun = capture && !rx_frame_error && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            rx_ack          <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            frame_error     <= 1'b0;
            overshoot_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rx_ack <= 1'b0;
                    if (rx_strobe_data_ready_level) state <= ACK;
                end
                ACK: begin
                    rx_ack <= 1'b1;
                    state  <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    rx_ack <= 1'b0;
                    if (!rx_strobe_data_ready_level) state <= IDLE;
                end
                default: begin
                    rx_ack <= 1'b0;
                    state  <= IDLE;
                end
            endcase

            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   if (!full) count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Set dominates a coincident clear.
            frame_error     <= (capture && rx_frame_error) ||
                               (frame_error && !cmd_clear_frame_error);
            overshoot_error <= overrun ||
                               (overshoot_error && !cmd_clear_overshoot_error);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= rx_data_in;
    end

    assign data_out   = empty ? '0 : mem[rd_ptr];
    assign status_out = {4'b0000, overshoot_error, frame_error, full, !empty};
    assign fifo_count = count;

`ifdef UART_RX_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= !irq_mask && (!empty || frame_error || overshoot_error);
    end
`endif

endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// Bench for uart_rx_buffer_ctrl: table of operations with expected status, plus
// a byte scoreboard queue checked on every pop, and a reset-during-WAIT_LOW sequence.
module tb_uart_rx_buffer_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] rx_data_in;
    logic          rx_strobe_data_ready_level;
    logic          rx_frame_error;
    logic          rx_ack;
    logic          cpu_strobe_read_data;
    logic          cmd_clear_frame_error;
    logic          cmd_clear_overshoot_error;
    logic [DW-1:0] data_out;
    logic [7:0]    status_out;
    logic [2:0]    fifo_count;

    uart_rx_buffer_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .rx_data_in                 (rx_data_in),
        .rx_strobe_data_ready_level (rx_strobe_data_ready_level),
        .rx_frame_error             (rx_frame_error),
        .rx_ack                     (rx_ack),
        .cpu_strobe_read_data       (cpu_strobe_read_data),
        .cmd_clear_frame_error      (cmd_clear_frame_error),
        .cmd_clear_overshoot_error  (cmd_clear_overshoot_error),
        .data_out                   (data_out),
        .status_out                 (status_out),
        .fifo_count                 (fifo_count)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {OP_RX, OP_RD, OP_CLRF, OP_CLRO} op_t;
    typedef struct {
        op_t        op;
        logic [7:0] d;
        logic       fe;
        logic       rd;
        logic       clro;
        logic [7:0] st;
        int         cnt;
        logic [7:0] dout;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];
    logic [7:0] prev_st;
    int         total = 0;
    int         bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic add(input op_t op, input logic [7:0] d, input logic fe, input logic rd,
                       input logic clro, input logic [7:0] st, input int cnt, input logic [7:0] dout);
        vec_t v;
        v.op = op; v.d = d; v.fe = fe; v.rd = rd; v.clro = clro;
        v.st = st; v.cnt = cnt; v.dout = dout;
        tbl.push_back(v);
    endtask

    task automatic pop_check(input string name);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        chk(name, {24'b0, data_out}, {24'b0, e});
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, "_status"}, {24'b0, status_out}, {24'b0, v.st});
        chk({tag, "_count"},  {29'b0, fifo_count}, v.cnt);
        chk({tag, "_dout"},   {24'b0, data_out},   {24'b0, v.dout});
    endtask

    task automatic run_vec(input vec_t v);
        case (v.op)
            OP_RX: begin
                rx_data_in                 = v.d;
                rx_frame_error             = v.fe;
                rx_strobe_data_ready_level = 1'b1;
                cpu_strobe_read_data       = v.rd;
                cmd_clear_overshoot_error  = v.clro;
                if (v.rd && exp_q.size() > 0) pop_check("rx_pop_head");
                if (!v.fe && (exp_q.size() < DEPTH || v.rd)) exp_q.push_back(v.d);
                tick();
                cpu_strobe_read_data      = 1'b0;
                cmd_clear_overshoot_error = 1'b0;
                check_outs("rx", v);
                chk("ack_early", {31'b0, rx_ack}, 0);
                tick();
                chk("ack_pulse", {31'b0, rx_ack}, 1);
                rx_strobe_data_ready_level = 1'b0;
                rx_frame_error             = 1'b0;
                tick();
                chk("ack_drop", {31'b0, rx_ack}, 0);
            end
            OP_RD: begin
                pop_check("rd_data");
                cpu_strobe_read_data = 1'b1;
                tick();
                cpu_strobe_read_data = 1'b0;
                check_outs("rd", v);
            end
            OP_CLRF: begin
                cmd_clear_frame_error = 1'b1;
                #1 chk("clrf_strobe_cycle", {24'b0, status_out}, {24'b0, prev_st});
                tick();
                cmd_clear_frame_error = 1'b0;
                check_outs("clrf", v);
            end
            default: begin
                cmd_clear_overshoot_error = 1'b1;
                #1 chk("clro_strobe_cycle", {24'b0, status_out}, {24'b0, prev_st});
                tick();
                cmd_clear_overshoot_error = 1'b0;
                check_outs("clro", v);
            end
        endcase
        prev_st = v.st;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rx_data_in = '0;
        rx_strobe_data_ready_level = 1'b0;
        rx_frame_error = 1'b0;
        cpu_strobe_read_data = 1'b0;
        cmd_clear_frame_error = 1'b0;
        cmd_clear_overshoot_error = 1'b0;
        prev_st = 8'h00;

        // op, data, fe, rd, clro, status, count, data_out
        add(OP_RX,   8'hAB, 0, 0, 0, 8'h01, 1, 8'hAB);
        add(OP_RD,   8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        add(OP_RX,   8'h11, 0, 0, 0, 8'h01, 1, 8'h11);
        add(OP_RX,   8'h22, 0, 0, 0, 8'h01, 2, 8'h11);
        add(OP_RX,   8'h33, 0, 0, 0, 8'h01, 3, 8'h11);
        add(OP_RX,   8'h44, 0, 0, 0, 8'h03, 4, 8'h11);
        add(OP_RX,   8'h55, 0, 0, 0, 8'h0B, 4, 8'h11);
        add(OP_RX,   8'h66, 0, 0, 1, 8'h0B, 4, 8'h11);
        add(OP_CLRO, 8'h00, 0, 0, 0, 8'h03, 4, 8'h11);
        add(OP_RD,   8'h00, 0, 0, 0, 8'h01, 3, 8'h22);
        add(OP_RD,   8'h00, 0, 0, 0, 8'h01, 2, 8'h33);
        add(OP_RD,   8'h00, 0, 0, 0, 8'h01, 1, 8'h44);
        add(OP_RD,   8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        add(OP_RX,   8'h11, 0, 0, 0, 8'h01, 1, 8'h11);
        add(OP_RX,   8'h22, 0, 0, 0, 8'h01, 2, 8'h11);
        add(OP_RX,   8'h33, 0, 0, 0, 8'h01, 3, 8'h11);
        add(OP_RX,   8'h44, 0, 0, 0, 8'h03, 4, 8'h11);
        add(OP_RX,   8'h55, 0, 1, 0, 8'h03, 4, 8'h22);
        add(OP_RD,   8'h00, 0, 0, 0, 8'h01, 3, 8'h33);
        add(OP_RD,   8'h00, 0, 0, 0, 8'h01, 2, 8'h44);
        add(OP_RD,   8'h00, 0, 0, 0, 8'h01, 1, 8'h55);
        add(OP_RD,   8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        add(OP_RX,   8'hBB, 1, 0, 0, 8'h04, 0, 8'h00);
        add(OP_CLRF, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        add(OP_RD,   8'h00, 0, 0, 0, 8'h00, 0, 8'h00);

        repeat (3) tick();
        reset = 1'b0;
        chk("reset_status", {24'b0, status_out}, 0);
        chk("reset_count",  {29'b0, fifo_count}, 0);
        chk("reset_dout",   {24'b0, data_out},   0);
        chk("reset_ack",    {31'b0, rx_ack},     0);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset while parked in WAIT_LOW with two bytes buffered.
        rx_data_in = 8'h71;
        rx_strobe_data_ready_level = 1'b1;
        exp_q.push_back(8'h71);
        tick(); tick();
        rx_strobe_data_ready_level = 1'b0;
        tick();
        rx_data_in = 8'h72;
        rx_strobe_data_ready_level = 1'b1;
        exp_q.push_back(8'h72);
        tick(); tick(); tick();
        chk("wl_count_before", {29'b0, fifo_count}, 2);
        chk("wl_ack_quiet",    {31'b0, rx_ack},     0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        chk("wl_rst_count",  {29'b0, fifo_count}, 0);
        chk("wl_rst_status", {24'b0, status_out}, 0);
        chk("wl_rst_ack",    {31'b0, rx_ack},     0);
        chk("wl_rst_dout",   {24'b0, data_out},   0);
        exp_q.push_back(8'h72);
        tick();
        chk("recap_count",  {29'b0, fifo_count}, 1);
        chk("recap_status", {24'b0, status_out}, 8'h01);
        pop_check("recap_dout");
        tick();
        chk("recap_ack", {31'b0, rx_ack}, 1);
        rx_strobe_data_ready_level = 1'b0;
        tick();
        chk("recap_ack_drop", {31'b0, rx_ack}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
